// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core.
// Fetch, execute and writeback complete in one clk.
module rv32i_core (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_val,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd,
  output logic [31:0] data_wr,
  output logic [3:0]  data_wr_en
);
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUI = 7'h17;
  localparam logic [6:0] OP_JAL = 7'h6f;
  localparam logic [6:0] OP_JLR = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_REG = 7'h33;

  logic [31:0] pc, pc4, pc_nxt, tgt;
  logic [31:0] rf [32];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] r1, r2;

  assign opc = inst_val[6:0];
  assign rd  = inst_val[11:7];
  assign f3  = inst_val[14:12];
  assign rs1 = inst_val[19:15];
  assign rs2 = inst_val[24:20];
  assign f7  = inst_val[31:25];
  assign r1  = rf[rs1];
  assign r2  = rf[rs2];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst_val[31]}}, inst_val[31:20]};
  assign imm_s = {{20{inst_val[31]}}, f7, rd};
  assign imm_b = {{19{inst_val[31]}}, inst_val[31],
                  inst_val[7], inst_val[30:25],
                  inst_val[11:8], 1'b0};
  assign imm_u = {inst_val[31:12], 12'b0};
  assign imm_j = {{11{inst_val[31]}}, inst_val[31],
                  inst_val[19:12], inst_val[20],
                  inst_val[30:21], 1'b0};

  // Unrecognised encodings decode to no flag at all and act as NOPs
  logic is_lui, is_aui, is_jal, is_jlr, is_br;
  logic is_ld, is_st, is_opi, is_op, sh_ok;
  assign sh_ok  = (f3 == 3'b001) ? (f7 == 7'h00) :
                  (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) :
                  1'b1;
  assign is_lui = opc == OP_LUI;
  assign is_aui = opc == OP_AUI;
  assign is_jal = opc == OP_JAL;
  assign is_jlr = opc == OP_JLR && f3 == 3'b000;
  assign is_br  = opc == OP_BR && f3[2:1] != 2'b01;
  assign is_ld  = opc == OP_LD &&
                  (f3 inside {3'b000, 3'b001, 3'b010,
                              3'b100, 3'b101});
  assign is_st  = opc == OP_ST &&
                  (f3 inside {3'b000, 3'b001, 3'b010});
  assign is_opi = opc == OP_IMM && sh_ok;
  assign is_op  = opc == OP_REG &&
                  (f7 == 7'h00 || (f7 == 7'h20 &&
                   (f3 == 3'b000 || f3 == 3'b101)));

  logic [31:0] a, b, alu, sra;
  logic [2:0]  fn;
  logic        alt;

  always_comb begin
    a   = r1;
    b   = imm_i;
    fn  = f3;
    alt = 1'b0;
    unique case (1'b1)
      is_lui: begin a = '0; b = imm_u; fn = 3'b000; end
      is_aui: begin a = pc; b = imm_u; fn = 3'b000; end
      is_st:  begin b = imm_s; fn = 3'b000; end
      is_op:  begin b = r2; alt = f7[5]; end
      is_opi: alt = (f3 == 3'b101) && f7[5];
      default: fn = 3'b000;
    endcase
  end

  assign sra = $signed(a) >>> b[4:0];

  always_comb begin
    case (fn)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? sra : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  end

  assign data_addr = alu;

  logic eq, lt, ltu, take;
  assign eq  = r1 == r2;
  assign lt  = $signed(r1) < $signed(r2);
  assign ltu = r1 < r2;

  always_comb begin
    case (f3[2:1])
      2'b00:   take = eq ^ f3[0];
      2'b10:   take = lt ^ f3[0];
      2'b11:   take = ltu ^ f3[0];
      default: take = 1'b0;
    endcase
  end

  assign pc4 = pc + 32'd4;

  always_comb begin
    tgt = pc4;
    unique case (1'b1)
      is_br:  if (take) tgt = pc + imm_b;
      is_jal: tgt = pc + imm_j;
      is_jlr: tgt = alu;
      default: ;
    endcase
    pc_nxt = {tgt[31:2], 2'b00};
  end

  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ldv;
  assign lb = data_rd[{data_addr[1:0], 3'b000} +: 8];
  assign lh = data_addr[1] ? data_rd[31:16] : data_rd[15:0];

  always_comb begin
    case (f3)
      3'b000:  ldv = {{24{lb[7]}}, lb};
      3'b001:  ldv = {{16{lh[15]}}, lh};
      3'b100:  ldv = {24'b0, lb};
      3'b101:  ldv = {16'b0, lh};
      default: ldv = data_rd;
    endcase
  end

  always_comb begin
    data_wr    = r2;
    data_wr_en = 4'b0000;
    if (is_st && !rst) begin
      case (f3[1:0])
        2'b00: begin
          data_wr    = {4{r2[7:0]}};
          data_wr_en = 4'b0001 << data_addr[1:0];
        end
        2'b01: begin
          data_wr    = {2{r2[15:0]}};
          data_wr_en = data_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: data_wr_en = 4'b1111;
      endcase
    end
  end

  logic        wb;
  logic [31:0] res;
  assign wb  = is_lui | is_aui | is_op | is_opi |
               is_ld | is_jal | is_jlr;
  assign res = (is_jal | is_jlr) ? pc4 :
               is_ld ? ldv : alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pc_nxt;
      if (wb && rd != 5'd0) rf[rd] <= res;
    end
  end

  assign inst_addr = pc;
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: program-driven bench for rv32i_core.
// Stores and PC trace are matched against queued expectations.
module tb_rv32i_core;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_addr, inst_val, data_addr;
  logic [31:0] data_rd, data_wr;
  logic [3:0]  data_wr_en;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  e;
  } st_t;

  logic [31:0] prog [64];
  st_t         sq[$];
  logic [31:0] pq[$];
  st_t         s;
  int          checks = 0;
  int          errors = 0;
  bit          sb_on = 1'b0;

  localparam logic [6:0] LUI = 7'h37;
  localparam logic [6:0] JLR = 7'h67;
  localparam logic [6:0] LD  = 7'h03;
  localparam logic [6:0] IMM = 7'h13;
  localparam logic [31:0] NOP = 32'h13;

  rv32i_core dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_val(inst_val),
    .data_addr(data_addr), .data_rd(data_rd),
    .data_wr(data_wr), .data_wr_en(data_wr_en)
  );

  always #5 clk = ~clk;

  assign inst_val = prog[inst_addr[7:2]];
  assign data_rd  = (data_addr[31:2] == 30'h0400_0000) ?
                    32'h8001_F0FF : 32'h0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_t(
    input logic [31:0] imm, input logic [31:0] rs1,
    input logic [31:0] f3, input logic [31:0] rd,
    input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] s_t(
    input logic [31:0] imm, input logic [31:0] rs2,
    input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0],
            imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(
    input logic [31:0] imm, input logic [31:0] rs2,
    input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0],
            f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] u_t(
    input logic [31:0] imm, input logic [31:0] rd,
    input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] j_t(
    input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] r_t(
    input logic [6:0] f7, input logic [31:0] rs2,
    input logic [31:0] rs1, input logic [31:0] f3,
    input logic [31:0] rd);
    return {f7, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = NOP;
  endtask

  task automatic push(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] e);
    st_t t;
    t.a = a; t.d = d; t.e = e;
    sq.push_back(t);
  endtask

  task automatic wait_pc(input logic [31:0] pc,
                         input int budget);
    int n = 0;
    while (inst_addr !== pc && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("reach_%h", pc), inst_addr, pc);
  endtask

  always @(negedge clk) begin
    if (sb_on && !rst && data_wr_en != 4'b0000) begin
      if (sq.size() == 0) begin
        check("stray_we", {28'b0, data_wr_en}, 32'h0);
      end else begin
        s = sq.pop_front();
        check("st_addr", data_addr, s.a);
        check("st_data", data_wr, s.d);
        check("st_en", {28'b0, data_wr_en}, {28'b0, s.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_prog();
    prog[0]  = i_t(5, 0, 0, 1, IMM);
    prog[1]  = i_t(-3, 1, 0, 2, IMM);
    prog[2]  = u_t(32'h20000, 3, LUI);
    prog[3]  = s_t(0, 2, 3, 2);
    prog[4]  = i_t(32'hA5, 0, 0, 1, IMM);
    prog[5]  = s_t(1, 1, 3, 0);
    prog[6]  = s_t(2, 1, 3, 1);
    prog[7]  = i_t(7, 0, 0, 0, IMM);
    prog[8]  = s_t(4, 0, 3, 2);
    prog[9]  = 32'h0000_0073;
    prog[10] = r_t(7'h20, 1, 2, 0, 4);
    prog[11] = s_t(8, 4, 3, 2);
    prog[12] = i_t(32'h404, 4, 5, 5, IMM);
    prog[13] = s_t(12, 5, 3, 2);
    prog[14] = r_t(7'h00, 4, 1, 3, 6);
    prog[15] = s_t(16, 6, 3, 2);
    prog[17] = b_t(-4, 0, 0, 0);

    #1 rst = 1'b1;
    #1;
    check("rst_pc", inst_addr, 32'h0);
    check("rst_we", {28'b0, data_wr_en}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 check("rel_pc1", inst_addr, 32'h4);
    @(posedge clk); #1 check("rel_pc2", inst_addr, 32'h8);
    wait_pc(32'h14, 40);
    check("sb_we_live", {28'b0, data_wr_en}, 32'h2);
    rst = 1'b1;
    #1;
    check("async_pc", inst_addr, 32'h0);
    check("async_we", {28'b0, data_wr_en}, 32'h0);

    sb_on = 1'b1;
    push(32'h2000_0000, 32'h2, 4'b1111);
    push(32'h2000_0001, 32'hA5A5_A5A5, 4'b0010);
    push(32'h2000_0002, 32'h00A5_00A5, 4'b1100);
    push(32'h2000_0004, 32'h0, 4'b1111);
    push(32'h2000_0008, 32'd2 - 32'hA5, 4'b1111);
    push(32'h2000_000C, 32'hFFFF_FFF5, 4'b1111);
    push(32'h2000_0010, 32'h1, 4'b1111);
    @(negedge clk) rst = 1'b0;
    wait_pc(32'h24, 40);
    @(posedge clk); #1 check("ecall_pc", inst_addr, 32'h28);
    wait_pc(32'h44, 40);
    @(posedge clk); #1 check("beq_back", inst_addr, 32'h40);
    repeat (4) @(posedge clk);
    #1 check("qa_empty", sq.size(), 0);

    rst = 1'b1;
    clear_prog();
    prog[0]  = u_t(32'h10000, 3, LUI);
    prog[1]  = u_t(32'h20000, 8, LUI);
    prog[2]  = i_t(0, 3, 0, 1, LD);
    prog[3]  = s_t(0, 1, 8, 2);
    prog[4]  = i_t(1, 3, 4, 1, LD);
    prog[5]  = s_t(4, 1, 8, 2);
    prog[6]  = i_t(2, 3, 1, 1, LD);
    prog[7]  = s_t(8, 1, 8, 2);
    prog[8]  = i_t(0, 3, 2, 1, LD);
    prog[9]  = s_t(12, 1, 8, 2);
    prog[10] = i_t(0, 3, 5, 1, LD);
    prog[11] = s_t(16, 1, 8, 2);
    prog[12] = b_t(0, 0, 0, 0);
    push(32'h2000_0000, 32'hFFFF_FFFF, 4'b1111);
    push(32'h2000_0004, 32'h0000_00F0, 4'b1111);
    push(32'h2000_0008, 32'hFFFF_8001, 4'b1111);
    push(32'h2000_000C, 32'h8001_F0FF, 4'b1111);
    push(32'h2000_0010, 32'h0000_F0FF, 4'b1111);
    @(negedge clk) rst = 1'b0;
    wait_pc(32'h30, 40);
    repeat (3) @(posedge clk);
    #1 check("qb_empty", sq.size(), 0);

    rst = 1'b1;
    clear_prog();
    prog[0]  = i_t(-1, 0, 0, 4, IMM);
    prog[1]  = i_t(1, 0, 0, 5, IMM);
    prog[2]  = b_t(8, 5, 4, 3'b100);
    prog[3]  = i_t(1, 0, 0, 9, IMM);
    prog[4]  = j_t(8, 1);
    prog[5]  = i_t(8, 1, 0, 1, IMM);
    prog[6]  = i_t(1, 1, 0, 0, JLR);
    prog[7]  = b_t(8, 5, 4, 3'b110);
    prog[8]  = s_t(0, 9, 0, 2);
    prog[9]  = j_t(8, 10);
    prog[11] = i_t(16, 10, 0, 10, JLR);
    prog[14] = s_t(4, 10, 0, 2);
    prog[16] = b_t(0, 0, 0, 0);
    push(32'h0, 32'h0, 4'b1111);
    push(32'h4, 32'h30, 4'b1111);
    pq = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h18,
           32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
           32'h2C, 32'h38, 32'h3C, 32'h40, 32'h40};
    @(negedge clk) rst = 1'b0;
    while (pq.size() > 0) begin
      check("pc_trace", inst_addr, pq.pop_front());
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1 check("qc_empty", sq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
